mcpu_core_exn_handler: RTL
==========================

Name: mcpu_core_exn_handler

Overview:
- Consumer side of the per-lane exception codes produced at the PC stage.
- Selects the winning lane and latches cause, lane and faulting packet PC (EPC), clears interrupt enable, and flushes the pipeline.
- After the pipeline reports drained, redirects fetch to the exception vector (EVEC).
- Also handles ERET: redirect to EPC and restore the saved interrupt enable. Sits between the PC stage and the fetch redirect / CSR logic.

Parameters:
EVEC_RESET, 28'h0, reset value of EVEC (packet address, byte address [31:4])
IE_RESET, 1'b0, reset value of interrupts_enabled

Ports:
clkrst_core_clk  in  1  core clock
clkrst_core_rst_n  in  1  asynchronous active-low reset
exception  in  1  PC stage reports an exception this cycle (already qualified by pc_valid)
combined_ec0..combined_ec3  in  5 each  per-lane codes from exn_codes.vh; EXN_CODE_NOERR = no fault
pc_packet_pc  in  28  packet address of the PC-stage packet
eret  in  1  PC stage executes ERET this cycle
drain_done  in  1  pipeline empty after flush
csr_wr_en  in  1  CSR write strobe
csr_wr_sel  in  2  0=EVEC, 1=EPC, 2=IE/saved-IE, 3=reserved (ignored)
csr_wr_data  in  32  EVEC/EPC take [31:4]; IE takes [0], saved IE takes [1]
flush  out  1  held high until drain_done
redirect_valid  out  1  one-cycle fetch redirect strobe
redirect_pc  out  28  redirect target
interrupts_enabled  out  1  global interrupt enable
exn_cause  out  5  latched winning code
exn_lane  out  2  latched winning lane
epc  out  28  latched faulting packet PC
evec  out  28  exception vector
busy  out  1  state != IDLE

Behaviour:
Reset (async, rst_n low):
- State = IDLE. flush=0, redirect_valid=0, redirect_pc=0, exn_cause=EXN_CODE_NOERR, exn_lane=0, epc=0.
- evec=EVEC_RESET, interrupts_enabled=IE_RESET, saved_ie=0.
- Reset mid-sequence aborts it immediately; nothing is pending after release.

States: IDLE, FLUSH, REDIRECT.

IDLE:
- exception=1:
  - Winner = lowest-numbered lane with code != NOERR (lane0 > 1 > 2 > 3).
  - Next edge: exn_cause/exn_lane = winner, epc = pc_packet_pc, saved_ie = interrupts_enabled, interrupts_enabled = 0.
  - Go to FLUSH.
  - If exception=1 but all codes are NOERR, it is ignored (no state change).
- eret=1 with no exception:
  - Next edge: interrupts_enabled = saved_ie, redirect_pc = epc, redirect_valid = 1 for one cycle. Stay in IDLE. No flush; the PC stage has already squashed younger work.
- exception and eret together: exception wins, eret is dropped.

FLUSH:
- flush=1 combinationally from the state.
- On drain_done=1, go to REDIRECT. Wait is unbounded.
- exception/eret are ignored while in this state.

REDIRECT:
- redirect_valid=1 and redirect_pc=evec for exactly one cycle. flush=0.
- Return to IDLE.
- Latency: exception cycle N, flush high from N+1; drain_done in cycle M gives redirect_valid in M+1.

CSR writes:
- Accepted only in IDLE; ignored otherwise.
- Same-cycle exception capture takes priority over an EPC or IE write. An EVEC write in that cycle still lands, and the later redirect uses the new EVEC.
- An ERET in the same cycle as an EPC write redirects to the old EPC.

Widths: all PCs are 28-bit packet addresses; no arithmetic and no wrap.

Test Plan:
- Reset then idle: rst_n low mid-FLUSH, release -> busy=0, flush=0, evec=EVEC_RESET, interrupts_enabled=IE_RESET, no redirect_valid.
- Lane priority: IE=1, exception=1, ec0=NOERR, ec1=EXN_CODE_DATA_PF, ec2=EXN_CODE_ILL, pc=28'h0000123 -> exn_lane=1, exn_cause=DATA_PF, epc=28'h0000123, IE=0, flush=1 next cycle.
- Flush/redirect handshake: evec=28'h0000400, drain_done asserted 5 cycles after flush -> flush stays high 5 cycles, then redirect_valid=1 for 1 cycle with redirect_pc=28'h0000400, busy drops after.
- ERET: after the above exception (saved_ie=1), eret=1 in IDLE -> redirect_valid pulse with redirect_pc=28'h0000123, interrupts_enabled=1, no flush.
- Simultaneous events: exception + eret + EPC CSR write (0xFFFF_FFF0) in one cycle -> exception taken, epc = pc_packet_pc (not 28'hFFFFFFF), eret dropped. exception during FLUSH -> exn_cause/epc unchanged.
- Degenerate: exception=1 with all codes NOERR -> no state change, no flush.

Source files
------------

// File: rtl/mcpu_core_exn_handler.sv
// rtl/mcpu_core_exn_handler.sv - exception capture, pipeline flush and EVEC/EPC fetch redirect
module mcpu_core_exn_handler #(
  parameter logic [27:0] EVEC_RESET = 28'h0,
  parameter logic        IE_RESET   = 1'b0
) (
  input  logic        clkrst_core_clk,
  input  logic        clkrst_core_rst_n,
  input  logic        exception,
  input  logic [4:0]  combined_ec0,
  input  logic [4:0]  combined_ec1,
  input  logic [4:0]  combined_ec2,
  input  logic [4:0]  combined_ec3,
  input  logic [27:0] pc_packet_pc,
  input  logic        eret,
  input  logic        drain_done,
  input  logic        csr_wr_en,
  input  logic [1:0]  csr_wr_sel,
  input  logic [31:0] csr_wr_data,
  output logic        flush,
  output logic        redirect_valid,
  output logic [27:0] redirect_pc,
  output logic        interrupts_enabled,
  output logic [4:0]  exn_cause,
  output logic [1:0]  exn_lane,
  output logic [27:0] epc,
  output logic [27:0] evec,
  output logic        busy
);

  localparam logic [4:0] EXN_CODE_NOERR = 5'h00;

  localparam logic [1:0] SEL_EVEC = 2'd0;
  localparam logic [1:0] SEL_EPC  = 2'd1;
  localparam logic [1:0] SEL_IE   = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic        saved_ie_q;
  logic        eret_pulse_q;
  logic [27:0] eret_pc_q;

  logic        any_fault;
  logic [1:0]  win_lane;
  logic [4:0]  win_code;
  logic        exn_take;
  logic        eret_take;
  logic        csr_ok;

  // Lane 0 is the oldest instruction in the packet, so it has priority.
  always_comb begin
    any_fault = 1'b1;
    win_lane  = 2'd0;
    win_code  = combined_ec0;
    if (combined_ec0 != EXN_CODE_NOERR) begin
      win_lane = 2'd0;
      win_code = combined_ec0;
    end else if (combined_ec1 != EXN_CODE_NOERR) begin
      win_lane = 2'd1;
      win_code = combined_ec1;
    end else if (combined_ec2 != EXN_CODE_NOERR) begin
      win_lane = 2'd2;
      win_code = combined_ec2;
    end else if (combined_ec3 != EXN_CODE_NOERR) begin
      win_lane = 2'd3;
      win_code = combined_ec3;
    end else begin
      any_fault = 1'b0;
    end
  end

  assign exn_take  = (state_q == IDLE) && exception && any_fault;
  assign eret_take = (state_q == IDLE) && eret && !exn_take;
  assign csr_ok    = (state_q == IDLE) && csr_wr_en;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (exn_take) state_d = FLUSH;
      FLUSH:    if (drain_done) state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      exn_cause          <= EXN_CODE_NOERR;
      exn_lane           <= 2'd0;
      epc                <= 28'h0;
      evec               <= EVEC_RESET;
      interrupts_enabled <= IE_RESET;
      saved_ie_q         <= 1'b0;
      eret_pulse_q       <= 1'b0;
      eret_pc_q          <= 28'h0;
    end else begin
      eret_pulse_q <= eret_take;
      if (csr_ok && csr_wr_sel == SEL_EVEC) begin
        evec <= csr_wr_data[31:4];
      end
      if (csr_ok && csr_wr_sel == SEL_EPC && !exn_take) begin
        epc <= csr_wr_data[31:4];
      end
      if (csr_ok && csr_wr_sel == SEL_IE && !exn_take) begin
        interrupts_enabled <= csr_wr_data[0];
        saved_ie_q         <= csr_wr_data[1];
      end
      if (exn_take) begin
        exn_cause          <= win_code;
        exn_lane           <= win_lane;
        epc                <= pc_packet_pc;
        saved_ie_q         <= interrupts_enabled;
        interrupts_enabled <= 1'b0;
      end
      // Non-blocking read of epc gives the pre-write value on a same-cycle EPC write.
      if (eret_take) begin
        interrupts_enabled <= saved_ie_q;
        eret_pc_q          <= epc;
      end
    end
  end

  assign flush          = (state_q == FLUSH);
  assign busy           = (state_q != IDLE);
  assign redirect_valid = (state_q == REDIRECT) || eret_pulse_q;
  assign redirect_pc    = (state_q == REDIRECT) ? evec : eret_pc_q;

endmodule
